// File: rtl/debug_bus_master.sv
// Byte-stream command bridge acting as a second initiator on the 32-bit system bus.
// Frames are opcode + address (+ data), answered with a status byte and optional read data.
module debug_bus_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic        rxReady,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        read,
    output logic        write,
    output logic [3:0]  bwe,
    output logic [31:0] address,
    output logic [31:0] dataOut,
    input  logic        waitRequest,
    input  logic        readValid,
    input  logic [31:0] dataIn,
    output logic [2:0]  debug_state
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [7:0] ST_OK      = 8'hA5;
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;
    localparam logic [7:0] ST_ILLEGAL = 8'hE1;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ADDR        = 3'd1,
        DATA        = 3'd2,
        BUS_REQ     = 3'd3,
        BUS_WAIT    = 3'd4,
        RESP_STATUS = 3'd5,
        RESP_DATA   = 3'd6
    } state_t;

    state_t        state, state_n;
    logic [1:0]    byte_cnt, byte_cnt_n;
    logic          is_write, is_write_n;
    logic          send_data, send_data_n;
    logic [TW-1:0] timer, timer_n;
    logic [31:0]   rdata, rdata_n;
    logic [7:0]    tx_data_n;
    logic          tx_valid_n;
    logic          read_n, write_n;
    logic [3:0]    bwe_n;
    logic [31:0]   address_n, data_out_n;

    logic rx_fire;
    logic accept;
    logic expired;

    // Command bytes are only taken while a frame is being collected.
    assign rxReady     = (state == IDLE) || (state == ADDR) || (state == DATA);
    assign rx_fire     = rxValid && rxReady;
    assign accept      = (read || write) && !waitRequest;
    assign expired     = (timer == TW'(TIMEOUT - 1));
    assign debug_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            byte_cnt  <= 2'd0;
            is_write  <= 1'b0;
            send_data <= 1'b0;
            timer     <= '0;
            rdata     <= 32'd0;
            txData    <= 8'd0;
            txValid   <= 1'b0;
            read      <= 1'b0;
            write     <= 1'b0;
            bwe       <= 4'd0;
            address   <= 32'd0;
            dataOut   <= 32'd0;
        end else begin
            state     <= state_n;
            byte_cnt  <= byte_cnt_n;
            is_write  <= is_write_n;
            send_data <= send_data_n;
            timer     <= timer_n;
            rdata     <= rdata_n;
            txData    <= tx_data_n;
            txValid   <= tx_valid_n;
            read      <= read_n;
            write     <= write_n;
            bwe       <= bwe_n;
            address   <= address_n;
            dataOut   <= data_out_n;
        end
    end

    always_comb begin
        state_n     = state;
        byte_cnt_n  = byte_cnt;
        is_write_n  = is_write;
        send_data_n = send_data;
        timer_n     = timer;
        rdata_n     = rdata;
        tx_data_n   = txData;
        tx_valid_n  = txValid;
        read_n      = read;
        write_n     = write;
        bwe_n       = bwe;
        address_n   = address;
        data_out_n  = dataOut;

        case (state)
            IDLE: begin
                if (rx_fire) begin
                    if ((rxData[1:0] == 2'b01) || (rxData[1:0] == 2'b10)) begin
                        is_write_n = (rxData[1:0] == 2'b01);
                        bwe_n      = (rxData[1:0] == 2'b01) ? rxData[7:4] : 4'd0;
                        byte_cnt_n = 2'd0;
                        state_n    = ADDR;
                    end else begin
                        bwe_n       = 4'd0;
                        send_data_n = 1'b0;
                        tx_data_n   = ST_ILLEGAL;
                        tx_valid_n  = 1'b1;
                        state_n     = RESP_STATUS;
                    end
                end
            end

            // Bytes arrive LSB first, so shifting in from the top leaves byte 0 at [7:0].
            ADDR: begin
                if (rx_fire) begin
                    address_n  = {rxData, address[31:8]};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (is_write) begin
                            state_n = DATA;
                        end else begin
                            read_n  = 1'b1;
                            timer_n = '0;
                            state_n = BUS_REQ;
                        end
                    end
                end
            end

            DATA: begin
                if (rx_fire) begin
                    data_out_n = {rxData, dataOut[31:8]};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        write_n = 1'b1;
                        timer_n = '0;
                        state_n = BUS_REQ;
                    end
                end
            end

            // A write accepted on the final cycle still completes; a read has not yet.
            BUS_REQ: begin
                timer_n = timer + 1'b1;
                if (accept && write) begin
                    write_n     = 1'b0;
                    send_data_n = 1'b0;
                    tx_data_n   = ST_OK;
                    tx_valid_n  = 1'b1;
                    state_n     = RESP_STATUS;
                end else if (expired) begin
                    read_n      = 1'b0;
                    write_n     = 1'b0;
                    send_data_n = 1'b0;
                    tx_data_n   = ST_TIMEOUT;
                    tx_valid_n  = 1'b1;
                    state_n     = RESP_STATUS;
                end else if (accept) begin
                    read_n  = 1'b0;
                    state_n = BUS_WAIT;
                end
            end

            // Returned data takes priority over a timeout firing in the same cycle.
            BUS_WAIT: begin
                timer_n = timer + 1'b1;
                if (readValid) begin
                    rdata_n     = dataIn;
                    send_data_n = 1'b1;
                    tx_data_n   = ST_OK;
                    tx_valid_n  = 1'b1;
                    state_n     = RESP_STATUS;
                end else if (expired) begin
                    send_data_n = 1'b0;
                    tx_data_n   = ST_TIMEOUT;
                    tx_valid_n  = 1'b1;
                    state_n     = RESP_STATUS;
                end
            end

            RESP_STATUS: begin
                if (txReady) begin
                    if (send_data) begin
                        byte_cnt_n = 2'd0;
                        tx_data_n  = rdata[7:0];
                        state_n    = RESP_DATA;
                    end else begin
                        tx_valid_n = 1'b0;
                        state_n    = IDLE;
                    end
                end
            end

            // rdata is shifted down as bytes leave so the next byte is always at [15:8].
            RESP_DATA: begin
                if (txReady) begin
                    if (byte_cnt == 2'd3) begin
                        tx_valid_n = 1'b0;
                        send_data_n = 1'b0;
                        state_n    = IDLE;
                    end else begin
                        byte_cnt_n = byte_cnt + 2'd1;
                        tx_data_n  = rdata[15:8];
                        rdata_n    = {8'd0, rdata[31:8]};
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
